booth_r4_seq_ctrl: RTL

Iterative signed 32x32 -> 64 multiplier controller built around the existing radix-4 partial-product cell generate_PPi.
- Accepts one operand pair through a valid/ready handshake.
- Steps through the 16 Booth triplets of Y, one per clock.
- Accumulates the shifted partial products into a 64-bit product.
- Presents the result through an output valid/ready handshake.
- Sits between the issue logic and the writeback stage of the multiply unit.

---
 rtl/mul_pkg.sv | 18 +
 rtl/generate_PPi.sv | 26 ++
 rtl/booth_r4_seq_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
package mul_pkg;

  localparam int unsigned W     = 32;
  localparam int unsigned NTRIP = 16;
  localparam int unsigned PW    = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [PW-1:0] sext33to64(input logic [W:0] v);
    return {{(PW - W - 1){v[W]}}, v};
  endfunction

endpackage

// File: rtl/generate_PPi.sv
// Radix-4 Booth partial-product cell: selects 0/+-X/+-2X as a one's-complement
// 33-bit value; sign=1 requests the +1 that completes the negation.
module generate_PPi (
  input  logic [31:0] X,
  input  logic [2:0]  Y_in,
  output logic [32:0] X_out,
  output logic        sign,
  output logic        E
);

  logic        sel_one;
  logic        sel_two;
  logic        neg;
  logic [32:0] mag;

  assign sel_one = Y_in[0] ^ Y_in[1];
  assign sel_two = (Y_in == 3'b011) || (Y_in == 3'b100);
  // 3'b111 encodes zero, so it must not request a negation.
  assign neg     = Y_in[2] & ~(Y_in[1] & Y_in[0]);

  assign mag   = sel_one ? {X[31], X} : (sel_two ? {X, 1'b0} : 33'd0);
  assign X_out = neg ? ~mag : mag;
  assign sign  = neg;
  assign E     = ~X_out[32];

endmodule

// File: rtl/booth_r4_seq_ctrl.sv
// Iterative signed 32x32->64 multiplier: one radix-4 Booth triplet per clock,
// operands in and product out over valid/ready handshakes.
module booth_r4_seq_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned W          = 32,
  parameter bit          EARLY_TERM = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    x,
  input  logic [W-1:0]    y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PW-1:0]   product,
  output logic            busy
);

  localparam int unsigned IW = $clog2(NTRIP);

  if (W != 32) begin : g_w_check
    $error("booth_r4_seq_ctrl: W must be 32 to match generate_PPi");
  end

  state_t          state;
  logic [W-1:0]    xr;
  logic [W:0]      yr;
  logic [IW-1:0]   i;
  logic [PW-1:0]   acc;

  logic [2:0]      trip_c;
  logic [W:0]      ppx_c;
  logic            pp_sign_c;
  logic            e_unused;
  logic [PW-1:0]   pp_c;
  logic [PW-1:0]   acc_next_c;
  logic [5:0]      rest_lsb_c;
  logic [W:0]      rest_mask_c;
  logic            rest_uniform_c;
  logic            last_c;

  assign trip_c = yr[{i, 1'b0} +: 3];

  generate_PPi u_ppi (
    .X     (xr),
    .Y_in  (trip_c),
    .X_out (ppx_c),
    .sign  (pp_sign_c),
    .E     (e_unused)
  );

  // Sign extension and the negation carry are handled here rather than via E.
  assign pp_c       = sext33to64(ppx_c) + PW'(pp_sign_c);
  assign acc_next_c = acc + (pp_c << {i, 1'b0});

  // y[31:2i+1] lives at yr[32:2i+2]; uniform bits mean every later triplet is 000/111.
  assign rest_lsb_c     = 6'({i, 1'b0}) + 6'd2;
  assign rest_mask_c    = ~((33'd1 << rest_lsb_c) - 33'd1);
  assign rest_uniform_c = ((yr & rest_mask_c) == 33'd0) ||
                          ((yr & rest_mask_c) == rest_mask_c);
  assign last_c         = (i == IW'(NTRIP - 1)) || (EARLY_TERM && rest_uniform_c);

  // Control FSM with accumulator, iteration counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      xr        <= '0;
      yr        <= '0;
      i         <= '0;
      acc       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            xr       <= x;
            yr       <= {y, 1'b0};
            acc      <= '0;
            i        <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next_c;
          i   <= i + IW'(1);
          if (last_c) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            product   <= acc;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
